// File: rtl/surf_scaler_bank.sv
// Per-channel rising-edge scaler bank: live counters are copied into a readable
// latched bank and cleared whenever the gate closes (external ref or internal timer).
module surf_scaler_bank #(
  parameter int unsigned NCH    = 32,
  parameter int unsigned CW     = 16,
  parameter int unsigned AW     = 5,
  parameter int unsigned PERIOD = 33000000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NCH-1:0]  hit_i,
  input  logic [NCH-1:0]  mask_i,
  input  logic            ref_i,
  input  logic            gate_sel_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [CW:0]     rd_dat_o,
  output logic            new_o,
  output logic [15:0]     gate_cnt_o
);

  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [NCH-1:0] hit_q;
  logic [NCH-1:0] inc_c;
  logic [CW-1:0]  cnt_q  [NCH];
  logic [NCH-1:0] sat_q;
  logic [CW:0]    bank_q [NCH];
  logic [TW-1:0]  timer_q;
  logic           sel_q;
  logic           sel_chg_c;
  logic           close_c;
  logic [CW:0]    rd_nxt_c;

  // Edge qualification and gate close decision
  always_comb begin
    inc_c     = hit_i & ~hit_q & ~mask_i;
    sel_chg_c = (gate_sel_i != sel_q);
    close_c   = gate_sel_i ? (!sel_chg_c && (timer_q == TMR_LAST)) : ref_i;
  end

  // Previous-cycle hit levels for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hit_q <= '0;
    else          hit_q <= hit_i;
  end

  // Internal gate timer; parked at 0 in external mode and on any mode change
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      sel_q <= gate_sel_i;
      if (sel_chg_c || !gate_sel_i || close_c) timer_q <= '0;
      else                                     timer_q <= timer_q + TW'(1);
    end
  end

  // Live counters with sticky saturation; an edge on the close cycle starts the new interval
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sat_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (close_c) begin
          bank_q[i] <= {sat_q[i], cnt_q[i]};
          cnt_q[i]  <= inc_c[i] ? CW'(1) : '0;
          sat_q[i]  <= 1'b0;
        end else if (inc_c[i]) begin
          if (cnt_q[i] == CNT_MAX) sat_q[i] <= 1'b1;
          else                     cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Readout mux; addresses beyond the bank return zero
  always_comb begin
    rd_nxt_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr_i == AW'(i)) rd_nxt_c = bank_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_dat_o   <= '0;
      new_o      <= 1'b0;
      gate_cnt_o <= '0;
    end else begin
      rd_dat_o <= rd_nxt_c;
      new_o    <= close_c;
      if (close_c) gate_cnt_o <= gate_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_surf_scaler_bank.sv
// Directed + random bench for surf_scaler_bank: two builds (CW=16 and CW=4) share
// stimulus and are checked each cycle against an unbounded-count reference model.
module tb_surf_scaler_bank;

  localparam int unsigned NCH    = 24;
  localparam int unsigned AW     = 5;
  localparam int unsigned PERIOD = 100;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [NCH-1:0]  hit_i = '0;
  logic [NCH-1:0]  mask_i = '0;
  logic            ref_i = 1'b0;
  logic            gate_sel_i = 1'b0;
  logic [AW-1:0]   rd_addr_i = '0;
  logic [16:0]     rd_dat_a;
  logic [4:0]      rd_dat_b;
  logic            new_a, new_b;
  logic [15:0]     gate_cnt_a, gate_cnt_b;

  surf_scaler_bank #(.NCH(NCH), .CW(16), .AW(AW), .PERIOD(PERIOD)) dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .hit_i(hit_i), .mask_i(mask_i), .ref_i(ref_i),
    .gate_sel_i(gate_sel_i), .rd_addr_i(rd_addr_i), .rd_dat_o(rd_dat_a), .new_o(new_a),
    .gate_cnt_o(gate_cnt_a));

  surf_scaler_bank #(.NCH(NCH), .CW(4), .AW(AW), .PERIOD(PERIOD)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .hit_i(hit_i), .mask_i(mask_i), .ref_i(ref_i),
    .gate_sel_i(gate_sel_i), .rd_addr_i(rd_addr_i), .rd_dat_o(rd_dat_b), .new_o(new_b),
    .gate_cnt_o(gate_cnt_b));

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain edge totals per interval, saturated only when latched
  int             ecnt   [NCH];
  int             bank_a [NCH];
  int             bank_b [NCH];
  logic [NCH-1:0] prev_hit;
  int             m_gate, m_timer, cyc;
  logic           m_prev_sel, exp_new;
  int             exp_rd_a, exp_rd_b;

  function automatic int sat_enc(input int c, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (c > mx) ? ((1 << cw) | mx) : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      ecnt[i] = 0; bank_a[i] = 0; bank_b[i] = 0;
    end
    prev_hit = '0; m_gate = 0; m_timer = 0; m_prev_sel = 1'b0;
    exp_new = 1'b0; exp_rd_a = 0; exp_rd_b = 0;
  endtask

  // Advance one clock: predict from the inputs currently applied, then compare
  task automatic tick();
    logic close;
    logic [NCH-1:0] inc;
    if (gate_sel_i) close = (gate_sel_i == m_prev_sel) && (m_timer == int'(PERIOD) - 1);
    else            close = ref_i;
    if (int'(rd_addr_i) < int'(NCH)) begin
      exp_rd_a = bank_a[rd_addr_i];
      exp_rd_b = bank_b[rd_addr_i];
    end else begin
      exp_rd_a = 0;
      exp_rd_b = 0;
    end
    inc = hit_i & ~prev_hit & ~mask_i;
    for (int i = 0; i < NCH; i++) begin
      if (close) begin
        bank_a[i] = sat_enc(ecnt[i], 16);
        bank_b[i] = sat_enc(ecnt[i], 4);
        ecnt[i]   = inc[i] ? 1 : 0;
      end else if (inc[i]) begin
        ecnt[i]++;
      end
    end
    if (close) m_gate = (m_gate + 1) % 65536;
    if (!gate_sel_i || (gate_sel_i != m_prev_sel) || close) m_timer = 0;
    else                                                    m_timer++;
    m_prev_sel = gate_sel_i;
    prev_hit   = hit_i;
    exp_new    = close;
    @(posedge clk_i);
    #1;
    cyc++;
    chk("rd_a", 32'(rd_dat_a), 32'(exp_rd_a));
    chk("rd_b", 32'(rd_dat_b), 32'(exp_rd_b));
    chk("new_a", 32'(new_a), 32'(exp_new));
    chk("new_b", 32'(new_b), 32'(exp_new));
    chk("gcnt_a", 32'(gate_cnt_a), 32'(m_gate));
    chk("gcnt_b", 32'(gate_cnt_b), 32'(m_gate));
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      hit_i[ch] = 1'b1; tick();
      hit_i[ch] = 1'b0; tick();
    end
  endtask

  task automatic gate_ref();
    ref_i = 1'b1; tick();
    ref_i = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic rst_pulse(input string tag);
    rst_n_i = 1'b0;
    #2;
    chk({tag, "_rd_a"}, 32'(rd_dat_a), 32'd0);
    chk({tag, "_rd_b"}, 32'(rd_dat_b), 32'd0);
    chk({tag, "_new"}, 32'({new_a, new_b}), 32'd0);
    chk({tag, "_gcnt"}, 32'(gate_cnt_a), 32'd0);
    model_clear();
    #2;
    rst_n_i = 1'b1;
  endtask

  int last_pulse, n_pulse;

  initial begin
    if (NCH > (1 << AW)) $fatal(1, "FAIL param_check NCH=%0d exceeds address space", NCH);
    model_clear();
    cyc = 0;
    #12;
    chk("rst_rd_a", 32'(rd_dat_a), 32'd0);
    chk("rst_new", 32'(new_a), 32'd0);
    chk("rst_gcnt", 32'(gate_cnt_a), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // Basic count: 5 pulses on channel 3
    pulse(3, 5);
    rd_addr_i = AW'(3);
    gate_ref();
    chk("basic_new", 32'(new_a), 32'd1);
    tick();
    chk("basic_ch3", 32'(rd_dat_a), 32'h5);
    rd_addr_i = AW'(4);
    tick();
    chk("basic_ch4", 32'(rd_dat_a), 32'h0);
    chk("basic_gcnt", 32'(gate_cnt_a), 32'd1);

    // Saturation on the CW=4 build
    rd_addr_i = AW'(0);
    pulse(0, 20);
    gate_ref();
    tick();
    chk("sat_b", 32'(rd_dat_b), 32'h1F);
    chk("sat_a", 32'(rd_dat_a), 32'd20);
    gate_ref();
    tick();
    chk("sat_empty", 32'(rd_dat_b), 32'h0);

    // Edge coincident with the gate close belongs to the next interval
    rd_addr_i = AW'(7);
    pulse(7, 3);
    hit_i[7] = 1'b1; ref_i = 1'b1; tick();
    hit_i[7] = 1'b0; ref_i = 1'b0; tick();
    chk("coin_first", 32'(rd_dat_a), 32'd3);
    repeat (9) tick();
    gate_ref();
    tick();
    chk("coin_second", 32'(rd_dat_a), 32'd1);

    // Back-to-back gate closes
    rd_addr_i = AW'(5);
    pulse(5, 2);
    hit_i[5] = 1'b1; ref_i = 1'b1; tick();
    chk("b2b_new1", 32'(new_a), 32'd1);
    hit_i[5] = 1'b0; tick();
    chk("b2b_new2", 32'(new_a), 32'd1);
    chk("b2b_first", 32'(rd_dat_a), 32'd2);
    ref_i = 1'b0; tick();
    chk("b2b_second", 32'(rd_dat_a), 32'd1);

    // Mask and address range
    mask_i[2] = 1'b1;
    rd_addr_i = AW'(2);
    pulse(2, 8);
    gate_ref();
    mask_i[2] = 1'b0;
    tick();
    chk("mask_ch2", 32'(rd_dat_a), 32'd0);
    rd_addr_i = AW'(NCH);
    tick();
    chk("addr_nch", 32'(rd_dat_a), 32'd0);
    rd_addr_i = '1;
    tick();
    chk("addr_max", 32'(rd_dat_a), 32'd0);

    // Internal gate with ref_i noise
    gate_sel_i = 1'b1;
    last_pulse = -1; n_pulse = 0;
    repeat (350) begin
      ref_i     = 1'($urandom_range(0, 1));
      hit_i     = NCH'($urandom());
      rd_addr_i = AW'($urandom_range(0, 31));
      tick();
      if (new_a) begin
        if (last_pulse >= 0) chk("int_period", 32'(cyc - last_pulse), 32'(PERIOD));
        last_pulse = cyc;
        n_pulse++;
      end
    end
    chk("int_npulse", 32'(n_pulse), 32'd3);
    ref_i = 1'b0; gate_sel_i = 1'b0;
    tick();

    // Random mode-0 traffic
    repeat (300) begin
      hit_i     = NCH'($urandom());
      mask_i    = NCH'($urandom()) & NCH'($urandom());
      ref_i     = ($urandom_range(0, 15) == 0);
      rd_addr_i = AW'($urandom_range(0, 31));
      tick();
    end
    hit_i = '0; mask_i = '0; ref_i = 1'b0;
    tick();

    // Reset mid-interval discards the partial count
    rd_addr_i = AW'(1);
    pulse(1, 3);
    rst_pulse("midrst");
    pulse(1, 2);
    gate_ref();
    tick();
    chk("midrst_ch1", 32'(rd_dat_a), 32'd2);
    chk("midrst_gcnt", 32'(gate_cnt_a), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/surf_scaler_bank.md
SURF_SCALER_BANK -- requirements
Module: surf_scaler_bank

Interface
REQ-001 Parameter NCH, default 32: number of trigger channels counted.
REQ-002 Parameter CW, default 16: counter width per channel, in bits.
REQ-003 Parameter AW, default 5: read-address width; the bench checks that NCH <= 2^AW.
REQ-004 Parameter PERIOD, default 33000000: internal gate length in clk_i cycles, used in gate_sel_i=1 mode.
REQ-005 Port clk_i, input, 1 bit: single clock for the whole block. All other inputs are synchronous to it.
REQ-006 Port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port hit_i, input, NCH bits: per-channel trigger level, already synchronised to clk_i.
REQ-008 Port mask_i, input, NCH bits: 1 inhibits counting on that channel.
REQ-009 Port ref_i, input, 1 bit: single-cycle reference pulse that closes the gate in external mode.
REQ-010 Port gate_sel_i, input, 1 bit: gate source select. 0 = ref_i, 1 = internal PERIOD timer.
REQ-011 Port rd_addr_i, input, AW bits: channel select for readout.
REQ-012 Port rd_dat_o, output, CW+1 bits: latched value {sat flag, count} for the selected channel.
REQ-013 Port new_o, output, 1 bit: one-cycle pulse when a new latched bank becomes valid.
REQ-014 Port gate_cnt_o, output, 16 bits: number of completed gates, wrapping at 65535.

Function
REQ-015 Rising-edge detection per channel: an edge is hit_i=1 in this cycle with hit_i=0 on the previous cycle. The previous-cycle register resets to 0.
REQ-016 A level held high counts once only. Edges arriving on consecutive cycles (1,0,1 pattern) each count.
REQ-017 A channel's live counter increments by 1 on each unmasked edge.
REQ-018 A masked channel's live counter holds. A mask change takes effect in the same cycle.
REQ-019 Saturation: a live counter at 2^CW-1 holds that value and sets its sticky sat bit; it never wraps.
REQ-020 Gate close event in mode 0: ref_i=1 in this cycle.
REQ-021 Gate close event in mode 1: the internal timer reaches PERIOD-1. The timer then reloads to 0.
REQ-022 In mode 1, ref_i is ignored. In mode 0, the internal timer is held at 0.
REQ-023 When gate_sel_i changes, the internal timer clears. No gate close event is generated by the change.
REQ-024 On a gate close event, all NCH pairs {sat, live count} are copied into the latched bank in the same cycle. In that cycle every live counter and sat bit clears.
REQ-025 An edge coincident with a gate close event loads that live counter with 1 instead of 0; the edge belongs to the new interval.
REQ-026 new_o pulses high exactly 1 cycle after the latch cycle.
REQ-027 gate_cnt_o increments with the same timing as new_o.
REQ-028 rd_dat_o is registered: it presents latched[rd_addr_i] 1 cycle after rd_addr_i is applied.
REQ-029 rd_addr_i >= NCH returns all zeros.
REQ-030 A read in the same cycle as a latch returns the old bank. The next cycle returns the new bank.
REQ-031 Back-to-back gate close events (ref_i high on 2 consecutive cycles) are legal. The second latch holds only the edges seen in the cycle between them, and new_o pulses twice.
REQ-032 No input has a handshake or backpressure. The latched bank remains valid until the next gate close event.

Reset
REQ-033 While rst_n_i=0, the following clear asynchronously:
- all live counters, sat bits and latched entries;
- the edge registers;
- the timer and gate_cnt_o;
- rd_dat_o (to 0) and new_o (to 0).
REQ-034 Reset asserted mid-interval discards all accumulated counts; no latch and no new_o pulse is produced.
REQ-035 Counting resumes on the first clk_i edge after rst_n_i deasserts. Any hit_i already high at that edge counts as an edge.

Verification
REQ-036 Scenario, basic count (mode 0, mask 0):
- Stimulus: 5 pulses on channel 3, then ref_i.
- Response: new_o pulses 1 cycle after ref_i; rd_addr_i=3 gives rd_dat_o=0x00005; channel 4 reads 0; gate_cnt_o=1.
REQ-037 Scenario, saturation (CW=4 build):
- Stimulus: 20 edges on channel 0, then ref_i.
- Response: rd_dat_o=0x1F (sat=1, count=15). The next empty interval reads 0x00.
REQ-038 Scenario, coincident edge and ref_i:
- Stimulus: edge on channel 7 in the same cycle as ref_i, then ref_i again 10 cycles later.
- Response: first latch holds channel 7 value excluding that edge; second latch holds 1.
REQ-039 Scenario, internal gate:
- Stimulus: PERIOD=100, gate_sel_i=1, ref_i toggled randomly.
- Response: new_o pulses every 100 cycles exactly; ref_i has no effect.
REQ-040 Scenario, mask and address range:
- Stimulus: mask_i[2]=1 with 8 edges on channel 2; then rd_addr_i=NCH.
- Response: channel 2 reads 0; the out-of-range address reads 0.
REQ-041 Scenario, reset mid-interval:
- Stimulus: 3 edges on channel 1, pulse rst_n_i low asynchronously, then 2 edges and ref_i.
- Response: rd_dat_o and new_o go 0 immediately on reset; channel 1 reads 2; gate_cnt_o=1.
